// File: rtl/led_colour_sequencer.sv
// LED colour sequencer: steps a WIDTH-bit colour code through 1..2^WIDTH-2,
// either on debounced button presses (manual) or on a free-running period (auto).
module led_colour_sequencer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             mode,
  input  logic             dir,
  input  logic             hold,
  output logic [WIDTH-1:0] colour,
  output logic             step,
  output logic             wrap
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_W = $clog2(AUTO_PERIOD);

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0]  TM_LAST = TM_W'(AUTO_PERIOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [WIDTH-1:0] MAX     = ONES - ONE;

  logic            sync1;
  logic            sync2;
  logic            db_level;
  logic            db_prev;
  logic [DB_W-1:0] db_cnt;
  logic [TM_W-1:0] timer;

  logic             req;
  logic [WIDTH-1:0] next_colour;
  logic             next_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (sync2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= sync2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // db_prev tracks unconditionally so a rise seen during hold or auto is consumed, not queued
  always_ff @(posedge clk) begin
    if (rst) db_prev <= 1'b0;
    else     db_prev <= db_level;
  end

  always_ff @(posedge clk) begin
    if (rst || !mode) begin
      timer <= '0;
    end else if (!hold) begin
      if (timer == TM_LAST) timer <= '0;
      else                  timer <= timer + 1'b1;
    end
  end

  always_comb begin
    req = 1'b0;
    if (!hold) begin
      if (mode) req = (timer == TM_LAST);
      else      req = db_level && !db_prev;
    end
  end

  always_comb begin
    next_colour = colour;
    next_wrap   = 1'b0;
    if (colour == '0 || colour == ONES) begin
      next_colour = dir ? MAX : ONE;
    end else if (!dir) begin
      if (colour == MAX) begin
        next_colour = ONE;
        next_wrap   = 1'b1;
      end else begin
        next_colour = colour + ONE;
      end
    end else begin
      if (colour == ONE) begin
        next_colour = MAX;
        next_wrap   = 1'b1;
      end else begin
        next_colour = colour - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      colour <= '0;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      step <= req;
      wrap <= req && next_wrap;
      if (req) colour <= next_colour;
    end
  end

endmodule

// File: tb/tb_led_colour_sequencer.sv
// Directed bench for led_colour_sequencer with WIDTH=3, DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
module tb_led_colour_sequencer;

  localparam int W  = 3;
  localparam int DB = 4;
  localparam int AP = 8;

  logic         clk = 1'b0;
  logic         rst, button, mode, dir, hold;
  logic [W-1:0] colour;
  logic         step, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         d;
    logic [W-1:0] c;
    logic         w;
  } vec_t;

  vec_t man_tab[9];
  vec_t auto_tab[5];

  led_colour_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clk(clk), .rst(rst), .button(button), .mode(mode), .dir(dir), .hold(hold),
    .colour(colour), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // n edges with no step expected and colour held
  task automatic run_quiet(input int n, input string name);
    int steps = 0;
    logic [W-1:0] c0;
    c0 = colour;
    for (int i = 0; i < n; i++) begin
      tick();
      if (step || wrap) steps++;
    end
    check({name, " steps"}, steps, 0);
    check({name, " colour"}, int'(colour), int'(c0));
  endtask

  // clean 10-cycle press; update must land exactly on edge DB+3
  task automatic press(input vec_t v, input string name);
    dir    = v.d;
    button = 1'b1;
    run_quiet(DB + 2, {name, " pre"});
    tick();
    check({name, " colour"}, int'(colour), int'(v.c));
    check({name, " step"}, int'(step), 1);
    check({name, " wrap"}, int'(wrap), int'(v.w));
    run_quiet(10 - (DB + 3), {name, " held"});
    button = 1'b0;
    run_quiet(8, {name, " release"});
  endtask

  initial begin
    man_tab[0] = '{1'b0, 3'd1, 1'b0};
    man_tab[1] = '{1'b0, 3'd2, 1'b0};
    man_tab[2] = '{1'b0, 3'd3, 1'b0};
    man_tab[3] = '{1'b0, 3'd4, 1'b0};
    man_tab[4] = '{1'b0, 3'd5, 1'b0};
    man_tab[5] = '{1'b0, 3'd6, 1'b0};
    man_tab[6] = '{1'b0, 3'd1, 1'b1};
    man_tab[7] = '{1'b1, 3'd6, 1'b1};
    man_tab[8] = '{1'b1, 3'd5, 1'b0};

    auto_tab[0] = '{1'b0, 3'd4, 1'b0};
    auto_tab[1] = '{1'b0, 3'd5, 1'b0};
    auto_tab[2] = '{1'b0, 3'd6, 1'b0};
    auto_tab[3] = '{1'b0, 3'd1, 1'b1};
    auto_tab[4] = '{1'b0, 3'd2, 1'b0};

    rst = 1'b1; button = 1'b0; mode = 1'b0; dir = 1'b0; hold = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset colour", int'(colour), 0);
    check("reset step", int'(step), 0);
    check("reset wrap", int'(wrap), 0);

    foreach (man_tab[i]) press(man_tab[i], $sformatf("press%0d", i));

    // glitches of 1..3 cycles must never qualify
    for (int len = 1; len <= 3; len++) begin
      button = 1'b1;
      run_quiet(len, $sformatf("glitch%0d hi", len));
      button = 1'b0;
      run_quiet(5, $sformatf("glitch%0d lo", len));
    end
    check("after glitches colour", int'(colour), 5);

    press('{1'b1, 3'd4, 1'b0}, "down to 4");
    press('{1'b1, 3'd3, 1'b0}, "down to 3");

    // auto mode with button activity that must be ignored
    mode = 1'b1;
    dir  = 1'b0;
    foreach (auto_tab[i]) begin
      int steps = 0;
      for (int t = 1; t <= AP; t++) begin
        button = (t >= 2 && t <= 6);
        tick();
        if (t < AP && step) steps++;
      end
      check($sformatf("auto%0d early steps", i), steps, 0);
      check($sformatf("auto%0d colour", i), int'(colour), int'(auto_tab[i].c));
      check($sformatf("auto%0d step", i), int'(step), 1);
      check($sformatf("auto%0d wrap", i), int'(wrap), int'(auto_tab[i].w));
    end
    button = 1'b0;

    // freeze at timer=5, then 3 more edges to the step
    run_quiet(5, "auto pre-hold");
    hold = 1'b1;
    run_quiet(20, "auto hold");
    hold = 1'b0;
    run_quiet(2, "auto post-hold");
    tick();
    check("auto resume colour", int'(colour), 3);
    check("auto resume step", int'(step), 1);

    // manual press qualified during hold is lost, even if hold drops while still pressed
    mode   = 1'b0;
    hold   = 1'b1;
    button = 1'b1;
    run_quiet(12, "manual hold press");
    hold = 1'b0;
    run_quiet(6, "manual hold released");
    button = 1'b0;
    run_quiet(8, "manual hold button up");

    // reset mid-timer and mid-debounce, then down-step from reset value
    mode   = 1'b1;
    dir    = 1'b1;
    button = 1'b1;
    run_quiet(4, "pre-reset auto");
    rst = 1'b1;
    tick();
    check("mid reset colour", int'(colour), 0);
    check("mid reset step", int'(step), 0);
    check("mid reset wrap", int'(wrap), 0);
    rst    = 1'b0;
    button = 1'b0;
    run_quiet(AP - 1, "auto after reset");
    tick();
    check("auto from 0 down colour", int'(colour), 6);
    check("auto from 0 down step", int'(step), 1);
    check("auto from 0 down wrap", int'(wrap), 0);

    // button held across reset re-qualifies to exactly one step
    mode   = 1'b0;
    dir    = 1'b0;
    button = 1'b1;
    run_quiet(3, "pre-reset manual");
    rst = 1'b1;
    tick();
    check("db reset colour", int'(colour), 0);
    check("db reset step", int'(step), 0);
    check("db reset wrap", int'(wrap), 0);
    rst = 1'b0;
    run_quiet(DB + 2, "requalify pre");
    tick();
    check("requalify colour", int'(colour), 1);
    check("requalify step", int'(step), 1);
    check("requalify wrap", int'(wrap), 0);
    run_quiet(10, "requalify held");
    button = 1'b0;
    run_quiet(8, "requalify release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
